// File: rtl/barrel_shift_arbiter_pkg.sv
// Shared shift opcodes and requester ids for the two-port shifter arbiter.
package barrel_shift_arbiter_pkg;
  typedef logic [1:0] shift_op_t;

  localparam shift_op_t OP_SLL = 2'b00;
  localparam shift_op_t OP_SRL = 2'b10;
  localparam shift_op_t OP_SRA = 2'b11;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;
endpackage

// File: rtl/barrel_shift_arbiter_shifter.sv
// Combinational barrel shifter; SHIFTER_TYPE picks one of three equivalent structures.
// Op encoding {LR,LA}: 0x = shift left, 10 = logical right, 11 = arithmetic right.
module barrel_shift_arbiter_shifter
  import barrel_shift_arbiter_pkg::*;
#(
  parameter int SHIFTER_TYPE = 0,
  parameter int WIDTH        = 32
) (
  input  logic [1:0]               i_op,
  input  logic [$clog2(WIDTH)-1:0] i_w,
  input  logic [WIDTH-1:0]         i_a,
  output logic [WIDTH-1:0]         o_y
);
  localparam int SW = $clog2(WIDTH);

  if (SHIFTER_TYPE == 0) begin : g_log
    logic [WIDTH-1:0] w_stage;
    logic             w_fill;
    logic             w_right;
    // log2(WIDTH) mux stages, stage s shifts by 2**s
    always_comb begin
      w_right = (i_op == OP_SRL) || (i_op == OP_SRA);
      w_fill  = (i_op == OP_SRA) && i_a[WIDTH-1];
      w_stage = i_a;
      for (int s = 0; s < SW; s++) begin
        if (i_w[s]) begin
          if (w_right)
            w_stage = (w_stage >> (1 << s)) |
                      ({WIDTH{w_fill}} & ~({WIDTH{1'b1}} >> (1 << s)));
          else
            w_stage = w_stage << (1 << s);
        end
      end
      o_y = w_stage;
    end
  end else if (SHIFTER_TYPE == 2) begin : g_rev
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_sh;
    logic             w_right;
    // right shifts reuse the left shifter on bit-reversed data
    always_comb begin
      w_right = i_op[1];
      w_in    = i_a;
      if (w_right)
        for (int i = 0; i < WIDTH; i++) w_in[i] = i_a[WIDTH-1-i];
      w_sh = w_in << i_w;
      if ((i_op == OP_SRA) && i_a[WIDTH-1])
        w_sh = w_sh | ~({WIDTH{1'b1}} << i_w);
      o_y = w_sh;
      if (w_right)
        for (int i = 0; i < WIDTH; i++) o_y[i] = w_sh[WIDTH-1-i];
    end
  end else begin : g_ops
    always_comb begin
      case (i_op)
        OP_SLL, 2'b01: o_y = i_a << i_w;
        OP_SRL:        o_y = i_a >> i_w;
        default:       o_y = $signed(i_a) >>> i_w;
      endcase
    end
  end
endmodule

// File: rtl/barrel_shift_arbiter.sv
// Two requesters share one barrel shifter: round-robin grant, operand reg -> result reg,
// one shift per cycle when unstalled; an output stall freezes S2, then S1, then drops READY.
module barrel_shift_arbiter
  import barrel_shift_arbiter_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SHIFTER_TYPE = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ0_VALID,
  output logic                     REQ0_READY,
  input  logic [1:0]               REQ0_OP,
  input  logic [$clog2(WIDTH)-1:0] REQ0_W,
  input  logic [WIDTH-1:0]         REQ0_A,
  input  logic                     REQ1_VALID,
  output logic                     REQ1_READY,
  input  logic [1:0]               REQ1_OP,
  input  logic [$clog2(WIDTH)-1:0] REQ1_W,
  input  logic [WIDTH-1:0]         REQ1_A,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic                     OUT_ID,
  output logic [WIDTH-1:0]         OUT_Y
);
  logic                     r_s1_v;
  shift_op_t                r_s1_op;
  logic [$clog2(WIDTH)-1:0] r_s1_w;
  logic [WIDTH-1:0]         r_s1_a;
  logic                     r_s1_id;
  logic                     r_ptr;
  logic                     r_out_v;
  logic                     r_out_id;
  logic [WIDTH-1:0]         r_out_y;

  logic                     w_adv1;
  logic                     w_adv2;
  logic                     w_gnt0;
  logic                     w_gnt1;
  logic [WIDTH-1:0]         w_shift_y;

  // READY is held low while reset is asserted, even if S1 is empty
  assign w_adv2 = ~r_out_v | OUT_READY;
  assign w_adv1 = ~RST & (~r_s1_v | w_adv2);
  assign w_gnt0 = w_adv1 & REQ0_VALID & (~REQ1_VALID | (r_ptr == ID_REQ0));
  assign w_gnt1 = w_adv1 & REQ1_VALID & (~REQ0_VALID | (r_ptr == ID_REQ1));

  assign REQ0_READY = w_gnt0;
  assign REQ1_READY = w_gnt1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr   <= ID_REQ0;
      r_s1_v  <= 1'b0;
      r_s1_op <= OP_SLL;
      r_s1_w  <= '0;
      r_s1_a  <= '0;
      r_s1_id <= ID_REQ0;
    end else begin
      if (w_gnt0)
        r_ptr <= ID_REQ1;
      else if (w_gnt1)
        r_ptr <= ID_REQ0;
      if (w_adv1) begin
        r_s1_v  <= w_gnt0 | w_gnt1;
        r_s1_id <= w_gnt1 ? ID_REQ1 : ID_REQ0;
        r_s1_op <= w_gnt1 ? REQ1_OP : REQ0_OP;
        r_s1_w  <= w_gnt1 ? REQ1_W  : REQ0_W;
        r_s1_a  <= w_gnt1 ? REQ1_A  : REQ0_A;
      end
    end
  end

  barrel_shift_arbiter_shifter #(
    .SHIFTER_TYPE (SHIFTER_TYPE),
    .WIDTH        (WIDTH)
  ) u_shifter (
    .i_op (r_s1_op),
    .i_w  (r_s1_w),
    .i_a  (r_s1_a),
    .o_y  (w_shift_y)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out_v  <= 1'b0;
      r_out_id <= ID_REQ0;
      r_out_y  <= '0;
    end else if (w_adv2) begin
      r_out_v  <= r_s1_v;
      r_out_id <= r_s1_id;
      r_out_y  <= w_shift_y;
    end
  end

  assign OUT_VALID = r_out_v;
  assign OUT_ID    = r_out_id;
  assign OUT_Y     = r_out_y;
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Drives three arbiter instances (one per shifter structure) with identical stimulus and
// checks each against a transaction-queue reference model.
module tb_barrel_shift_arbiter;
  import barrel_shift_arbiter_pkg::*;

  localparam int WIDTH = 32;
  localparam int SW    = $clog2(WIDTH);

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             RST;
  logic             v0, v1, out_rdy;
  logic [1:0]       op0, op1;
  logic [SW-1:0]    w0, w1;
  logic [WIDTH-1:0] a0, a1;

  logic [2:0]            rdy0, rdy1, ov, oid;
  logic [2:0][WIDTH-1:0] oy;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    barrel_shift_arbiter #(.WIDTH(WIDTH), .SHIFTER_TYPE(g)) u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .REQ0_VALID (v0),
      .REQ0_READY (rdy0[g]),
      .REQ0_OP    (op0),
      .REQ0_W     (w0),
      .REQ0_A     (a0),
      .REQ1_VALID (v1),
      .REQ1_READY (rdy1[g]),
      .REQ1_OP    (op1),
      .REQ1_W     (w1),
      .REQ1_A     (a1),
      .OUT_VALID  (ov[g]),
      .OUT_READY  (out_rdy),
      .OUT_ID     (oid[g]),
      .OUT_Y      (oy[g])
    );
  end

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] y;
    int               stamp;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  logic  ptr_m = 1'b0;
  logic  exp_g0, exp_g1, exp_ov;
  int    checks = 0;
  int    errors = 0;

  // Shift expressed as multiplication / floor division by 2**w
  function automatic logic [WIDTH-1:0] ref_shift(logic [1:0] op, int w, logic [WIDTH-1:0] a);
    longint p2, ua, sv, r;
    p2 = longint'(1) << w;
    ua = longint'(a);
    if (!op[1])
      r = ua * p2;
    else if (!op[0] || !a[WIDTH-1])
      r = ua / p2;
    else begin
      sv = ua - (longint'(1) << WIDTH);
      r  = (sv - (p2 - 1)) / p2;
    end
    return r[WIDTH-1:0];
  endfunction

  task automatic chk(string tag, int k, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, take the edge, update the model
  task automatic step();
    logic cap;
    #2;
    exp_ov = (q.size() > 0) && (cyc >= q[0].stamp + 2);
    cap    = !RST && ((q.size() < 2) || out_rdy);
    exp_g0 = cap && v0 && (!v1 || ptr_m == 1'b0);
    exp_g1 = cap && v1 && (!v0 || ptr_m == 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("ready0", k, rdy0[k], exp_g0);
      chk("ready1", k, rdy1[k], exp_g1);
      chk("out_valid", k, ov[k], exp_ov);
      if (exp_ov) begin
        chk("out_id", k, oid[k], q[0].id);
        chk("out_y", k, oy[k], q[0].y);
      end
    end
    @(posedge CLK);
    if (!RST) begin
      if (exp_ov && out_rdy) void'(q.pop_front());
      if (exp_g0) begin
        q.push_back('{id: 1'b0, y: ref_shift(op0, int'(w0), a0), stamp: cyc});
        ptr_m = 1'b1;
      end
      if (exp_g1) begin
        q.push_back('{id: 1'b1, y: ref_shift(op1, int'(w1), a1), stamp: cyc});
        ptr_m = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic rand_payload(output logic [1:0] op, output logic [SW-1:0] w, output logic [WIDTH-1:0] a);
    op = 2'($urandom_range(3));
    w  = SW'($urandom_range(WIDTH - 1));
    case ($urandom_range(3))
      0:       a = 32'h8000_0000 | WIDTH'($urandom);
      1:       a = 32'h0000_0001;
      default: a = WIDTH'($urandom);
    endcase
  endtask

  task automatic do_reset();
    RST = 1'b1;
    q.delete();
    ptr_m = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", k, ov[k], 1'b0);
      chk("rst_ready0", k, rdy0[k], 1'b0);
      chk("rst_ready1", k, rdy1[k], 1'b0);
      chk("rst_out_id", k, oid[k], 1'b0);
      chk("rst_out_y", k, oy[k], 0);
    end
    step();
    RST = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] y_hold;
    logic             gq[$];
    int               n0, n1;

    RST = 1'b1; out_rdy = 1'b1;
    v0 = 1'b1; v1 = 1'b1;
    op0 = OP_SLL; w0 = '0; a0 = '0;
    op1 = OP_SLL; w1 = '0; a1 = '0;
    #3;
    do_reset();
    v0 = 1'b0; v1 = 1'b0;

    // single SLL, two-cycle latency
    v0 = 1'b1; op0 = OP_SLL; a0 = 32'h0000_0001; w0 = 5'd4;
    step();
    v0 = 1'b0;
    step();
    chk("t1_valid", 0, ov[0], 1'b1);
    chk("t1_y", 0, oy[0], 32'h0000_0010);
    chk("t1_id", 0, oid[0], 1'b0);
    step();

    // right shifts of the sign bit
    v1 = 1'b1; op1 = OP_SRA; a1 = 32'h8000_0000; w1 = 5'd31;
    step();
    op1 = OP_SRL;
    step();
    chk("t2_sra", 0, oy[0], 32'hFFFF_FFFF);
    chk("t2_id", 0, oid[0], 1'b1);
    w1 = 5'd0;
    step();
    chk("t2_srl", 0, oy[0], 32'h0000_0001);
    v1 = 1'b0;
    step();
    chk("t2_w0", 0, oy[0], 32'h8000_0000);
    step();

    // both requesters busy: strict alternation
    n0 = 0; n1 = 0;
    rand_payload(op0, w0, a0);
    rand_payload(op1, w1, a1);
    for (int c = 0; c < 40 && (n0 < 6 || n1 < 6); c++) begin
      v0 = (n0 < 6); v1 = (n1 < 6);
      step();
      if (exp_g0) begin n0++; gq.push_back(1'b0); rand_payload(op0, w0, a0); end
      if (exp_g1) begin n1++; gq.push_back(1'b1); rand_payload(op1, w1, a1); end
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("t3_grants0", 0, rdy0[0] === 1'b0 ? n0 : -1, 6);
    chk("t3_grants1", 0, n1, 6);
    for (int i = 1; i < gq.size(); i++) chk("t3_alternate", 0, gq[i], !gq[i-1]);
    step(); step();

    // stream from requester 0 with a three-cycle output stall
    v0 = 1'b1;
    rand_payload(op0, w0, a0);
    for (int c = 0; c < 3; c++) begin
      step();
      if (exp_g0) rand_payload(op0, w0, a0);
    end
    out_rdy = 1'b0;
    step();
    if (exp_g0) rand_payload(op0, w0, a0);
    y_hold = oy[0];
    for (int c = 0; c < 2; c++) begin
      step();
      chk("t4_hold", 0, oy[0], y_hold);
      chk("t4_ready_low", 0, rdy0[0], 1'b0);
    end
    out_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (exp_g0) rand_payload(op0, w0, a0);
    end
    v0 = 1'b0;
    step(); step(); step();

    // reset with both stages full
    out_rdy = 1'b0; v0 = 1'b1; v1 = 1'b1;
    step(); step(); step();
    do_reset();
    out_rdy = 1'b1;
    step();
    chk("t5_ptr_req0", 0, exp_g0, 1'b1);
    if (exp_g0) rand_payload(op0, w0, a0);
    v0 = 1'b0;
    step();
    if (exp_g1) v1 = 1'b0;
    step(); step(); step();
    v1 = 1'b0;

    // random traffic, random back-pressure, occasional reset
    for (int c = 0; c < 800; c++) begin
      if (!v0 && $urandom_range(2) != 0) begin v0 = 1'b1; rand_payload(op0, w0, a0); end
      if (!v1 && $urandom_range(2) != 0) begin v1 = 1'b1; rand_payload(op1, w1, a1); end
      out_rdy = ($urandom_range(9) < 7);
      if ($urandom_range(249) == 0) begin
        do_reset();
      end else begin
        step();
        if (exp_g0) v0 = 1'b0;
        if (exp_g1) v1 = 1'b0;
      end
    end
    v0 = 1'b0; v1 = 1'b0; out_rdy = 1'b1;
    for (int c = 0; c < 4; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
